// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin sharing of one UART transmitter between the game-logic status
// channel (source 0) and the host message channel (source 1). Each granted
// byte is sent as a two-byte frame: source header, then payload. A watchdog
// aborts a frame if the TX never acknowledges a start by raising tx_busy.
module uart_tx_arbiter #(
    parameter logic [7:0] HDR0    = 8'hA0,
    parameter logic [7:0] HDR1    = 8'hB0,
    parameter int         TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       src0_valid,
    input  logic [7:0] src0_data,
    output logic       src0_ack,
    input  logic       src1_valid,
    input  logic [7:0] src1_data,
    output logic       src1_ack,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    output logic [1:0] grant,
    output logic       arb_busy,
    output logic       tx_err,
    input  logic       err_clr,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR_SEND = 3'd1,
        HDR_HI   = 3'd2,
        HDR_LO   = 3'd3,
        DAT_SEND = 3'd4,
        DAT_HI   = 3'd5,
        DAT_LO   = 3'd6
    } state_t;

    // Last watchdog value that may still see tx_busy arrive in time.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic       last_grant_r;     // 1 = source 1 was served last
    logic       last_nxt_s;
    logic [7:0] payload_r;
    logic [7:0] payload_nxt_s;
    logic [7:0] wd_r;
    logic [7:0] wd_nxt_s;
    logic       ack0_nxt_s;
    logic       ack1_nxt_s;
    logic       start_nxt_s;
    logic [7:0] byte_nxt_s;
    logic [1:0] grant_nxt_s;
    logic       err_set_s;
    logic       frame_inc_s;

    // Header byte belonging to the source that owns the current frame.
    function automatic logic [7:0] hdr_byte(input logic sel);
        if (sel) begin
            return HDR1;
        end else begin
            return HDR0;
        end
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and next values for every registered output.
    always_comb begin
        state_nxt_s   = state_r;
        ack0_nxt_s    = 1'b0;
        ack1_nxt_s    = 1'b0;
        start_nxt_s   = 1'b0;
        byte_nxt_s    = tx_byte;
        grant_nxt_s   = grant;
        last_nxt_s    = last_grant_r;
        payload_nxt_s = payload_r;
        wd_nxt_s      = wd_r;
        err_set_s     = 1'b0;
        frame_inc_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // Source 0 wins unless source 1 also asks and source 0 went last.
                if (src0_valid && (!src1_valid || last_grant_r)) begin
                    ack0_nxt_s    = 1'b1;
                    payload_nxt_s = src0_data;
                    grant_nxt_s   = 2'b01;
                    last_nxt_s    = 1'b0;
                    state_nxt_s   = HDR_SEND;
                end else if (src1_valid) begin
                    ack1_nxt_s    = 1'b1;
                    payload_nxt_s = src1_data;
                    grant_nxt_s   = 2'b10;
                    last_nxt_s    = 1'b1;
                    state_nxt_s   = HDR_SEND;
                end else begin
                    grant_nxt_s   = 2'b00;
                end
            end
            HDR_SEND: begin
                if (!tx_busy) begin
                    start_nxt_s = 1'b1;
                    byte_nxt_s  = hdr_byte(last_grant_r);
                    wd_nxt_s    = 8'd0;
                    state_nxt_s = HDR_HI;
                end else begin
                    state_nxt_s = HDR_SEND;
                end
            end
            HDR_HI: begin
                if (tx_busy) begin
                    state_nxt_s = HDR_LO;
                end else if (wd_r == WD_LAST) begin
                    err_set_s   = 1'b1;
                    grant_nxt_s = 2'b00;
                    state_nxt_s = IDLE;
                end else begin
                    wd_nxt_s    = wd_r + 8'd1;
                end
            end
            HDR_LO: begin
                if (!tx_busy) begin
                    state_nxt_s = DAT_SEND;
                end else begin
                    state_nxt_s = HDR_LO;
                end
            end
            DAT_SEND: begin
                if (!tx_busy) begin
                    start_nxt_s = 1'b1;
                    byte_nxt_s  = payload_r;
                    wd_nxt_s    = 8'd0;
                    state_nxt_s = DAT_HI;
                end else begin
                    state_nxt_s = DAT_SEND;
                end
            end
            DAT_HI: begin
                if (tx_busy) begin
                    state_nxt_s = DAT_LO;
                end else if (wd_r == WD_LAST) begin
                    err_set_s   = 1'b1;
                    grant_nxt_s = 2'b00;
                    state_nxt_s = IDLE;
                end else begin
                    wd_nxt_s    = wd_r + 8'd1;
                end
            end
            DAT_LO: begin
                if (!tx_busy) begin
                    frame_inc_s = 1'b1;
                    grant_nxt_s = 2'b00;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DAT_LO;
                end
            end
            default: begin
                grant_nxt_s = 2'b00;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Registered outputs, payload, round-robin pointer and watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src0_ack     <= 1'b0;
            src1_ack     <= 1'b0;
            tx_start     <= 1'b0;
            tx_byte      <= 8'h00;
            grant        <= 2'b00;
            arb_busy     <= 1'b0;
            tx_err       <= 1'b0;
            frame_cnt    <= 8'd0;
            last_grant_r <= 1'b1;
            payload_r    <= 8'h00;
            wd_r         <= 8'd0;
        end else begin
            src0_ack     <= ack0_nxt_s;
            src1_ack     <= ack1_nxt_s;
            tx_start     <= start_nxt_s;
            tx_byte      <= byte_nxt_s;
            grant        <= grant_nxt_s;
            arb_busy     <= (state_nxt_s != IDLE);
            last_grant_r <= last_nxt_s;
            payload_r    <= payload_nxt_s;
            wd_r         <= wd_nxt_s;
            // A new timeout takes priority over a clear in the same cycle.
            if (err_set_s) begin
                tx_err <= 1'b1;
            end else if (err_clr) begin
                tx_err <= 1'b0;
            end else begin
                tx_err <= tx_err;
            end
            if (frame_inc_s) begin
                frame_cnt <= frame_cnt + 8'd1;
            end else begin
                frame_cnt <= frame_cnt;
            end
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between two byte sources: the game-logic status channel (source 0) and the host message channel (source 1). Each granted byte goes out as a two-byte frame: a source header byte, then the payload byte. Sources are served round-robin, and the block enforces the TX start/busy handshake with a watchdog. It sits between the game and host logic and the UART TX datapath, which previously had only a single hard-wired driver.

## Interface
- HDR0, 8'hA0, header byte sent before each source-0 payload
- HDR1, 8'hB0, header byte sent before each source-1 payload
- TIMEOUT, 16, cycles allowed from tx_start until tx_busy must be seen high (legal range 2..255)
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- src0_valid  in  1  source 0 has a byte; held high until src0_ack
- src0_data  in  8  source 0 payload; stable while src0_valid is high
- src0_ack  out  1  one-cycle pulse: payload captured
- src1_valid, src1_data, src1_ack  same as source 0, for source 1
- tx_busy  in  1  UART TX is shifting a byte
- tx_start  out  1  one-cycle pulse: load tx_byte
- tx_byte  out  8  byte for the TX; held from tx_start until the next load
- grant  out  2  one-hot owner of the frame in flight (bit0 = src0); 2'b00 when idle
- arb_busy  out  1  high in every state except IDLE
- tx_err  out  1  sticky watchdog error
- err_clr  in  1  clears tx_err
- frame_cnt  out  8  count of completed frames; wraps 255 -> 0

## Operation
- States: IDLE, HDR_SEND, HDR_HI, HDR_LO, DAT_SEND, DAT_HI, DAT_LO.
- **IDLE**
  - If any srcN_valid is high, grant one source.
  - If both are valid, grant the source not in last_grant.
  - In the grant cycle: pulse srcN_ack, capture srcN_data into the payload register, set grant and last_grant, go to HDR_SEND.
- **HDR_SEND**
  - Wait while tx_busy = 1.
  - When tx_busy = 0: pulse tx_start with tx_byte = HDRn, clear the watchdog, go to HDR_HI.
- **HDR_HI**
  - tx_busy = 1 moves to HDR_LO.
  - Otherwise the watchdog counts. If it reaches TIMEOUT, abort to IDLE: set tx_err, grant = 0, frame_cnt unchanged. The captured payload is dropped.
- **HDR_LO**: tx_busy = 0 moves to DAT_SEND. No timeout applies here.
- **DAT_SEND / DAT_HI / DAT_LO**: same as the HDR states, but send the payload byte.
- **Frame completion**: leaving DAT_LO increments frame_cnt (mod 256) and returns to IDLE with grant = 0.
- **Source rules**
  - A source that deasserts valid before ack is simply not granted.
  - Valid arriving mid-frame waits; it is never lost and never acked early.
- **tx_err**
  - err_clr = 1 clears it.
  - If err_clr and a new timeout occur in the same cycle, tx_err ends set (set wins).
  - tx_err does not block arbitration.

## Timing
- Reset values:
  - state IDLE
  - src0_ack, src1_ack, tx_start = 0
  - tx_byte = 8'h00, grant = 2'b00
  - arb_busy, tx_err = 0, frame_cnt = 0
  - last_grant = src1, so src0 wins the first tie
- Reset mid-frame returns to IDLE immediately. No further tx_start is issued; the TX finishes its current byte on its own.
- Grant latency: valid seen in IDLE at edge k gives ack high during cycle k+1.
- tx_start latency: earliest at cycle k+2 (HDR_SEND with tx_busy = 0).
- tx_start, ack and the frame_cnt increment are exactly one cycle wide.
- Back-to-back: at most one IDLE cycle between frames, even when the same single source stays valid.
- Watchdog: tx_busy seen on the TIMEOUT-th cycle after tx_start is a success. Not seen by then is an error.

## Test plan
- **Single source**: src0_valid with 8'h41; a TX model raises busy 2 cycles after start for 10 cycles. Required: ack on cycle 1, tx_byte sequence A0 then 41, frame_cnt = 1, grant back to 00.
- **Contention**: src0 and src1 both valid continuously with distinct data. Required: frames alternate src0, src1, src0, …; headers alternate A0/B0; no ack lost or duplicated.
- **Busy at grant**: tx_busy already high from a prior byte when the grant occurs. Required: tx_start withheld until busy falls, then issued within 1 cycle.
- **Watchdog**: TIMEOUT = 4, TX never raises busy. Required: tx_err set 4 cycles after the header start, return to IDLE, frame_cnt unchanged. Then err_clr clears tx_err; same-cycle clear and new error leaves tx_err = 1.
- **Reset mid-frame**: rst pulse during DAT_HI. Required: all outputs at reset values the same cycle; next request starts from an A0/B0 header.
- **Counter wrap**: 256 completed frames. Required: frame_cnt reads 0 after the last frame, with no error.
